// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider for DIV/DIVU (LO=quotient, HI=remainder)
// Optional DIV_EARLY_OUT_EN: finish in one edge when divisor magnitude exceeds dividend magnitude.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic             sgn_q, sgn_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             dvs_neg_q, dvs_neg_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, trial;

  always_comb begin
    a_neg  = signed_op & dividend[WIDTH-1];
    b_neg  = signed_op & divisor[WIDTH-1];
    a_mag  = a_neg ? -dividend : dividend;
    b_mag  = b_neg ? -divisor : divisor;
    // trial[WIDTH] is the borrow: set when the shifted remainder is below the divisor
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_q};

    state_d   = state_q;
    sgn_d     = sgn_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    zero_d    = zero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sgn_d     = signed_op;
          dvd_neg_d = a_neg;
          dvs_neg_d = b_neg;
          rem_d     = '0;
          dvd_d     = a_mag;
          dvs_d     = b_mag;
          cnt_d     = '0;
          busy_d    = 1'b1;
          zero_d    = 1'b0;
          // dvd/rem are preloaded with the final divide-by-zero results
          if (divisor == '0) begin
            zero_d  = 1'b1;
            rem_d   = dividend;
            dvd_d   = '1;
            state_d = FIX;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (b_mag > a_mag) begin
            rem_d   = a_mag;
            dvd_d   = '0;
            state_d = FIX;
          end
`endif
          else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (zero_q) begin
          quo_d = dvd_q;
          rmd_d = rem_q;
          dbz_d = 1'b1;
        end else begin
          quo_d = (sgn_q & (dvd_neg_q ^ dvs_neg_q)) ? -dvd_q : dvd_q;
          rmd_d = (sgn_q & dvd_neg_q) ? -rem_q : rem_q;
          dbz_d = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sgn_q     <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      zero_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rmd_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sgn_q     <= sgn_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      zero_q    <= zero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      rmd_q     <= rmd_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative integer divider for the MIPS datapath. It performs the inverse of the adder path: division by repeated restoring subtraction, one quotient bit per cycle.
- Executes DIV and DIVU and produces quotient (LO) and remainder (HI).
- Sits beside the ALU. The control unit starts it and stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand/result width in bits; must be at least 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- signed_op  input  1  1=DIV (two's complement), 0=DIVU
- dividend  input  WIDTH  numerator, sampled with start
- divisor  input  WIDTH  denominator, sampled with start
- busy  output  1  operation in progress
- done  output  1  single-cycle pulse; results valid
- quotient  output  WIDTH  LO result
- remainder  output  WIDTH  HI result
- div_by_zero  output  1  last operation had divisor=0

Behaviour:
- Reset: the synchronous rst outranks all other inputs, including mid-operation.
  - Outputs: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Any in-flight operation is abandoned; no done pulse follows.
- States: IDLE, RUN, FIX.
- IDLE with start=1, sampled at edge E0:
  - Latch signed_op and the operand signs.
  - Take magnitudes: two's-complement negate negative operands when signed_op=1; raw values otherwise.
  - Clear the partial remainder, load the dividend magnitude, clear the iteration counter, set busy=1.
  - If divisor=0 (checked on raw inputs), go to FIX with the zero flag set; otherwise go to RUN.
- RUN, edges E1..E_WIDTH, one iteration per edge:
  - Shift {rem, dvd} left by 1.
  - trial = rem_shifted − divisor_mag, computed at WIDTH+1 bits to keep the borrow.
  - If no borrow: rem = trial and quotient bit = 1; else keep rem_shifted and quotient bit = 0.
  - Counter is ceil(log2(WIDTH+1)) bits; it goes to FIX after WIDTH iterations.
- FIX, one edge: E_{WIDTH+1}, or E1 for divide-by-zero.
  - Quotient is negated if signed_op and the operand signs differ.
  - Remainder takes the dividend's sign (negated if signed_op and the dividend is negative).
  - Register quotient, remainder and div_by_zero; set done=1 and busy=0; return to IDLE.
- Latency: done is seen in the cycle after E_{WIDTH+1}, i.e. WIDTH+1 edges after start is sampled (33 for WIDTH=32).
- done is high for exactly one cycle. Results and div_by_zero hold until the next operation's FIX edge.
- start while busy=1 is ignored: no queueing, and operands are not resampled.
- start in the cycle done=1 is accepted, which gives back-to-back operations.
- Divide by zero:
  - quotient = all ones, remainder = raw dividend, div_by_zero=1.
  - Latency is 1 edge; the sign fix is skipped.
- Signed overflow, −2^(WIDTH−1) / −1: quotient = 0x80000000, remainder = 0, no flag. This falls out of the magnitude arithmetic with wrapping negation.
- div_by_zero is cleared at the FIX edge of any non-zero-divisor operation.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN
- Defined: at E0, if divisor≠0 and divisor magnitude > dividend magnitude, go directly to FIX with quotient=0 and remainder=dividend magnitude. The normal sign fix applies, so remainder = the raw dividend value. done is seen after E1 (latency 1).
- Undefined: every non-zero divisor takes the full WIDTH+1 edges; the comparator is not built.

Test Plan:
- Reset, then DIVU 100/7, start for 1 cycle → busy for 33 cycles; done is one cycle with quotient=14, remainder=2, div_by_zero=0.
- DIV −100/7 (0xFFFFFF9C / 7) → quotient=0xFFFFFFF2 (−14), remainder=0xFFFFFFFE (−2). DIV 100/−7 → quotient −14, remainder 2.
- DIV 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. DIVU 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0.
- DIVU 55/0 → done after 1 edge; quotient=0xFFFFFFFF, remainder=55, div_by_zero=1. A following 9/3 clears the flag: quotient=3, remainder=0.
- Start 1000/10; pulse start with 5/5 at iteration 10 → ignored, result is 100/0. Assert rst at iteration 20 → all outputs 0, no done; a fresh 8/3 then gives quotient=2, remainder=2.
- With DIV_EARLY_OUT_EN, DIVU 3/10 → done after 1 edge, quotient=0, remainder=3. Without the macro → 33 edges, same result.
